// File: rtl/display_pkg.sv
// Shared 640x480@60 display timing constants, coordinate width and rgb888 pixel type.
package display_pkg;

    localparam int unsigned CORDW   = 10;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_RES   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam int unsigned COLR_W  = 8;

    typedef struct packed {
        logic [COLR_W-1:0] r;
        logic [COLR_W-1:0] g;
        logic [COLR_W-1:0] b;
    } rgb888_t;

endpackage

// File: rtl/pix_timing_gen_if.sv
// Renderer-facing scan/RGB signals plus the aligned pixel bus towards pix2gpdi.
interface pix_timing_gen_if;
    import display_pkg::*;

    logic [CORDW-1:0]  sx;
    logic [CORDW-1:0]  sy;
    logic              line;
    logic              frame;
    logic [COLR_W-1:0] red_in;
    logic [COLR_W-1:0] green_in;
    logic [COLR_W-1:0] blue_in;
    logic              test_en;
    logic [COLR_W-1:0] red;
    logic [COLR_W-1:0] green;
    logic [COLR_W-1:0] blue;
    logic              de;
    logic              hsync;
    logic              vsync;

    modport master (
        output sx, sy, line, frame, red, green, blue, de, hsync, vsync,
        input  red_in, green_in, blue_in, test_en
    );

    modport slave (
        input  sx, sy, line, frame, red, green, blue, de, hsync, vsync,
        output red_in, green_in, blue_in, test_en
    );

endinterface

// File: rtl/pix_delay.sv
// Generic N-stage shift register with synchronous active-low reset to RST_VAL; N=0 is a wire.
module pix_delay #(
    parameter int unsigned   W       = 1,
    parameter int unsigned   N       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (N == 0) begin : g_pass
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage [N];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(N); i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < int'(N); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[N-1];
    end

endmodule

// File: rtl/pix_timing_gen.sv
// Raster scan counters, sync/de decode and renderer-latency alignment for the pixel output bus.
// Optional colour-bar test pattern enabled by defining PIX_TESTPAT_EN.
module pix_timing_gen
    import display_pkg::*;
#(
    parameter int unsigned H_RES     = display_pkg::H_RES,
    parameter int unsigned H_FP      = display_pkg::H_FP,
    parameter int unsigned H_SYNC    = display_pkg::H_SYNC,
    parameter int unsigned H_BP      = display_pkg::H_BP,
    parameter int unsigned V_RES     = display_pkg::V_RES,
    parameter int unsigned V_FP      = display_pkg::V_FP,
    parameter int unsigned V_SYNC    = display_pkg::V_SYNC,
    parameter int unsigned V_BP      = display_pkg::V_BP,
    parameter logic        H_POL     = 1'b0,
    parameter logic        V_POL     = 1'b0,
    parameter int unsigned PIXEL_LAT = 2
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    pix_timing_gen_if.master        bus
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_RES + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_RES + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam logic [2:0]  TIM_IDLE = {1'b0, ~H_POL, ~V_POL};

    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic [CORDW-1:0] sx_next;
    logic [CORDW-1:0] sy_next;
    logic             line;
    logic             frame;

    always_comb begin
        sx_next = sx + CORDW'(1);
        sy_next = sy;
        if (sx == CORDW'(H_TOTAL - 1)) begin
            sx_next = '0;
            sy_next = (sy == CORDW'(V_TOTAL - 1)) ? '0 : sy + CORDW'(1);
        end
    end

    // line/frame are decoded from the next position so they coincide with sx/sy.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            sx    <= CORDW'(H_TOTAL - 1);
            sy    <= CORDW'(V_TOTAL - 1);
            line  <= 1'b0;
            frame <= 1'b0;
        end else begin
            sx    <= sx_next;
            sy    <= sy_next;
            line  <= (sx_next == '0);
            frame <= (sx_next == '0) && (sy_next == '0);
        end
    end

    logic de_c;
    logic hs_c;
    logic vs_c;

    always_comb begin
        de_c = (sx < CORDW'(H_RES)) && (sy < CORDW'(V_RES));
        hs_c = ((sx >= CORDW'(HS_BEG)) && (sx < CORDW'(HS_END))) ? H_POL : ~H_POL;
        vs_c = ((sy >= CORDW'(VS_BEG)) && (sy < CORDW'(VS_END))) ? V_POL : ~V_POL;
    end

    logic [2:0] tim_d;

    pix_delay #(
        .W       (3),
        .N       (PIXEL_LAT),
        .RST_VAL (TIM_IDLE)
    ) u_tim_dly (
        .clk   (clk_pix),
        .rst_n (rst_pix_n),
        .d     ({de_c, hs_c, vs_c}),
        .q     (tim_d)
    );

    rgb888_t rgb_src_c;

`ifdef PIX_TESTPAT_EN
    localparam int unsigned BAR_W = H_RES / 8;

    logic [CORDW-1:0] bar_px;
    logic [CORDW-1:0] bar_px_next;
    logic [2:0]       bar_idx;
    logic [2:0]       bar_idx_next;
    logic             pat_on;
    logic             pat_sel_c;
    rgb888_t          bar_c;
    logic [3*COLR_W:0] bar_q;
    logic             pat_sel_d;
    rgb888_t          bar_d;

    always_comb begin
        bar_px_next  = bar_px + CORDW'(1);
        bar_idx_next = bar_idx;
        if (sx_next == '0) begin
            bar_px_next  = '0;
            bar_idx_next = '0;
        end else if (bar_px == CORDW'(BAR_W - 1)) begin
            bar_px_next  = '0;
            bar_idx_next = bar_idx + 3'(1);
        end
    end

    // test_en only takes effect at the frame pulse so a frame never mixes sources.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
            pat_on  <= 1'b0;
        end else begin
            bar_px  <= bar_px_next;
            bar_idx <= bar_idx_next;
            if (frame) pat_on <= bus.test_en;
        end
    end

    always_comb begin
        pat_sel_c = frame ? bus.test_en : pat_on;
        bar_c.r   = {COLR_W{bar_idx[2]}};
        bar_c.g   = {COLR_W{bar_idx[1]}};
        bar_c.b   = {COLR_W{bar_idx[0]}};
    end

    pix_delay #(
        .W       (3*COLR_W + 1),
        .N       (PIXEL_LAT),
        .RST_VAL ('0)
    ) u_bar_dly (
        .clk   (clk_pix),
        .rst_n (rst_pix_n),
        .d     ({pat_sel_c, bar_c}),
        .q     (bar_q)
    );

    always_comb begin
        pat_sel_d = bar_q[3*COLR_W];
        bar_d     = rgb888_t'(bar_q[3*COLR_W-1:0]);
        rgb_src_c = bar_d;
        if (!pat_sel_d) begin
            rgb_src_c.r = bus.red_in;
            rgb_src_c.g = bus.green_in;
            rgb_src_c.b = bus.blue_in;
        end
    end
`else
    always_comb begin
        rgb_src_c.r = bus.red_in;
        rgb_src_c.g = bus.green_in;
        rgb_src_c.b = bus.blue_in;
    end
`endif

    rgb888_t rgb_q;
    logic    de_q;
    logic    hs_q;
    logic    vs_q;

    // Final alignment register; colour is forced to black outside the active area.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
        end else begin
            rgb_q <= tim_d[2] ? rgb_src_c : '0;
            de_q  <= tim_d[2];
            hs_q  <= tim_d[1];
            vs_q  <= tim_d[0];
        end
    end

    assign bus.sx    = sx;
    assign bus.sy    = sy;
    assign bus.line  = line;
    assign bus.frame = frame;
    assign bus.red   = rgb_q.r;
    assign bus.green = rgb_q.g;
    assign bus.blue  = rgb_q.b;
    assign bus.de    = de_q;
    assign bus.hsync = hs_q;
    assign bus.vsync = vs_q;

endmodule

// File: tb/tb_pix_timing_gen.sv
// Directed bench for pix_timing_gen on a reduced 24x13 raster with a 2-cycle renderer model.
module tb_pix_timing_gen;
    import display_pkg::*;

    localparam int HRES = 16, HFP = 2, HSYNC = 4, HBP = 2;
    localparam int VRES = 8,  VFP = 1, VSYNC = 2, VBP = 2;
    localparam int HT = HRES + HFP + HSYNC + HBP;
    localparam int VT = VRES + VFP + VSYNC + VBP;
    localparam int FT = HT * VT;
    localparam int LAT = 2;
    localparam int NOPAT = 1 << 30;
    localparam int NV = 18;

    typedef struct packed {
        logic [9:0] sx;
        logic [9:0] sy;
        logic       line;
        logic       frame;
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } outs_t;

    typedef struct {
        int    c;
        outs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pix_timing_gen_if bus_if ();

    pix_timing_gen #(
        .H_RES (HRES), .H_FP (HFP), .H_SYNC (HSYNC), .H_BP (HBP),
        .V_RES (VRES), .V_FP (VFP), .V_SYNC (VSYNC), .V_BP (VBP),
        .H_POL (1'b0), .V_POL (1'b0), .PIXEL_LAT (LAT)
    ) dut (
        .clk_pix   (clk),
        .rst_pix_n (rst_n),
        .bus       (bus_if)
    );

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc;
    int   pat_frame;
    bit   tbl_en;
    int   tbl_idx;
    int   last_frame, last_line, hs_run;
    int   h_sx [3];
    int   h_sy [3];
    vec_t vecs [NV];
    outs_t idle_o;

    function automatic vec_t mk(int c, int sx, int sy, bit ln, bit fr, bit de, bit hs, bit vs,
                                logic [7:0] r, logic [7:0] g, logic [7:0] b);
        vec_t v;
        v.c = c;
        v.e = '{sx: 10'(sx), sy: 10'(sy), line: ln, frame: fr, de: de, hs: hs, vs: vs,
                r: r, g: g, b: b};
        return v;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o = '{sx: bus_if.sx, sy: bus_if.sy, line: bus_if.line, frame: bus_if.frame,
              de: bus_if.de, hs: bus_if.hsync, vs: bus_if.vsync,
              r: bus_if.red, g: bus_if.green, b: bus_if.blue};
        return o;
    endfunction

    // Expected outputs in cycle c after release; colour outputs show pixel c-LAT-1.
    function automatic outs_t model(int c, int pf);
        outs_t o;
        int p, x, y;
        logic [2:0] bar;
        o = '{sx: 10'(c % HT), sy: 10'((c / HT) % VT), line: (c % HT) == 0,
              frame: (c % FT) == 0, de: 1'b0, hs: 1'b1, vs: 1'b1, r: 8'h0, g: 8'h0, b: 8'h0};
        p = c - 1 - LAT;
        if (p >= 0) begin
            x = p % HT;
            y = (p / HT) % VT;
            o.de = (x < HRES) && (y < VRES);
            o.hs = !((x >= HRES + HFP) && (x < HRES + HFP + HSYNC));
            o.vs = !((y >= VRES + VFP) && (y < VRES + VFP + VSYNC));
            if (o.de) begin
                if (p / FT >= pf) begin
                    bar = 3'(x / (HRES / 8));
                    o.r = {8{bar[2]}};
                    o.g = {8{bar[1]}};
                    o.b = {8{bar[0]}};
                end else begin
                    o.r = 8'(x);
                    o.g = 8'(y);
                    o.b = 8'hA5;
                end
            end
        end
        return o;
    endfunction

    task automatic fail_o(input string nm, input outs_t a, input outs_t e);
        err_cnt++;
        $display("FAIL %s cyc=%0d act sx=%0d sy=%0d ln=%b fr=%b de=%b hs=%b vs=%b rgb=%h_%h_%h exp sx=%0d sy=%0d ln=%b fr=%b de=%b hs=%b vs=%b rgb=%h_%h_%h",
                 nm, cyc, a.sx, a.sy, a.line, a.frame, a.de, a.hs, a.vs, a.r, a.g, a.b,
                 e.sx, e.sy, e.line, e.frame, e.de, e.hs, e.vs, e.r, e.g, e.b);
    endtask

    task automatic fail_i(input string nm, input int a, input int e);
        err_cnt++;
        $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, a, e);
    endtask

    // Advance one clock; the renderer answers with the pixel seen LAT cycles earlier.
    task automatic step();
        @(posedge clk);
        #1;
        h_sx[2] = h_sx[1]; h_sx[1] = h_sx[0]; h_sx[0] = int'(bus_if.sx);
        h_sy[2] = h_sy[1]; h_sy[1] = h_sy[0]; h_sy[0] = int'(bus_if.sy);
        if (h_sx[2] < HRES) begin
            bus_if.red_in   = 8'(h_sx[2]);
            bus_if.green_in = 8'(h_sy[2]);
            bus_if.blue_in  = 8'hA5;
        end else begin
            bus_if.red_in   = 8'hFF;
            bus_if.green_in = 8'hFF;
            bus_if.blue_in  = 8'hFF;
        end
    endtask

    task automatic tick();
        step();
        cyc++;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        step();
        cyc        = 0;
        last_frame = -1;
        last_line  = -1;
        hs_run     = 0;
    endtask

    task automatic check_cycle();
        outs_t a, e;
        a = sample();
        e = model(cyc, pat_frame);
        vec_cnt++;
        if (a !== e) fail_o("scan", a, e);
        if (tbl_en && tbl_idx < NV && vecs[tbl_idx].c == cyc) begin
            vec_cnt++;
            if (a !== vecs[tbl_idx].e) fail_o("table", a, vecs[tbl_idx].e);
            tbl_idx++;
        end
        if (a.frame === 1'b1) begin
            if (last_frame >= 0) begin
                vec_cnt++;
                if (cyc - last_frame != FT) fail_i("frame_period", cyc - last_frame, FT);
            end
            last_frame = cyc;
        end
        if (a.line === 1'b1) begin
            if (last_line >= 0) begin
                vec_cnt++;
                if (cyc - last_line != HT) fail_i("line_period", cyc - last_line, HT);
            end
            last_line = cyc;
        end
        if (a.hs === 1'b0) begin
            hs_run++;
        end else if (hs_run > 0) begin
            vec_cnt++;
            if (hs_run != HSYNC) fail_i("hsync_width", hs_run, HSYNC);
            hs_run = 0;
        end
    endtask

    initial begin
        bit found;
        vecs[0]  = mk(0,   0,  0, 1, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        vecs[1]  = mk(1,   1,  0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        vecs[2]  = mk(3,   3,  0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'hA5);
        vecs[3]  = mk(8,   8,  0, 0, 0, 1, 1, 1, 8'h05, 8'h00, 8'hA5);
        vecs[4]  = mk(18, 18,  0, 0, 0, 1, 1, 1, 8'h0F, 8'h00, 8'hA5);
        vecs[5]  = mk(19, 19,  0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        vecs[6]  = mk(21, 21,  0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        vecs[7]  = mk(24,  0,  1, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        vecs[8]  = mk(25,  1,  1, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        vecs[9]  = mk(27,  3,  1, 0, 0, 1, 1, 1, 8'h00, 8'h01, 8'hA5);
        vecs[10] = mk(186, 18, 7, 0, 0, 1, 1, 1, 8'h0F, 8'h07, 8'hA5);
        vecs[11] = mk(195,  3, 8, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        vecs[12] = mk(219,  3, 9, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        vecs[13] = mk(266,  2, 11, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        vecs[14] = mk(267,  3, 11, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        vecs[15] = mk(311, 23, 12, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        vecs[16] = mk(312,  0,  0, 1, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        vecs[17] = mk(315,  3,  0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'hA5);
        idle_o = '{sx: 10'(HT - 1), sy: 10'(VT - 1), line: 1'b0, frame: 1'b0, de: 1'b0,
                   hs: 1'b1, vs: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};

        for (int i = 0; i < 3; i++) begin
            h_sx[i] = HT - 1;
            h_sy[i] = VT - 1;
        end
        bus_if.red_in   = 8'h00;
        bus_if.green_in = 8'h00;
        bus_if.blue_in  = 8'h00;
        bus_if.test_en  = 1'b0;
        cyc       = 0;
        pat_frame = NOPAT;
        tbl_en    = 1'b0;
        tbl_idx   = 0;
        hs_run    = 0;

        // Reset held for 5 cycles, then two full frames from release.
        rst_n = 1'b0;
        repeat (5) step();
        vec_cnt++;
        if (sample() !== idle_o) fail_o("reset_idle", sample(), idle_o);

        release_rst();
        tbl_en = 1'b1;
        check_cycle();
        repeat (2 * FT + 6) begin
            tick();
            check_cycle();
        end
        vec_cnt++;
        if (tbl_idx != NV) fail_i("table_reached", tbl_idx, NV);
        tbl_en = 1'b0;

        // One-cycle reset inside an hsync pulse, mid-frame.
        found = 1'b0;
        for (int i = 0; i < FT + HT && !found; i++) begin
            tick();
            check_cycle();
            if (bus_if.sx == 10'd22 && bus_if.sy == 10'd5) found = 1'b1;
        end
        vec_cnt++;
        if (!found) fail_i("midrst_find", 0, 1);
        rst_n = 1'b0;
        step();
        hs_run = 0;
        vec_cnt++;
        if (sample() !== idle_o) fail_o("midrst_idle", sample(), idle_o);

        release_rst();
        check_cycle();
        repeat (FT + 100) begin
            tick();
            check_cycle();
        end

        // test_en raised mid-frame; with the pattern built in it starts at the next frame.
        bus_if.test_en = 1'b1;
`ifdef PIX_TESTPAT_EN
        pat_frame = cyc / FT + 1;
`else
        pat_frame = NOPAT;
`endif
        repeat (2 * FT) begin
            tick();
            check_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
